// File: rtl/bif_refresh_timeout.sv
// rtl/bif_refresh_timeout.sv - refresh request generator and bus-cycle watchdog for the BIF
// Registered REFRQ_n/TOUT/REFOVF/PEND_CNT, all state on OSC rising edge, async active-low clear.
module bif_refresh_timeout #(
  parameter int REF_PERIOD = 240,
  parameter int TOUT_LIMIT = 1023,
  parameter int PEND_MAX   = 7
) (
  input  logic       OSC,
  input  logic       CLEAR_n,
  input  logic       ENREF,
  input  logic       REF_n,
  input  logic       BDAP_n,
  input  logic       BDRY_n,
  output logic       REFRQ_n,
  output logic       TOUT,
  output logic       REFOVF,
  output logic [2:0] PEND_CNT
);

  localparam logic [11:0] PS_LAST  = 12'(REF_PERIOD - 1);
  localparam logic [11:0] TC_LAST  = 12'(TOUT_LIMIT - 1);
  localparam logic [2:0]  PEND_TOP = 3'(PEND_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_EXPIRED = 2'd2
  } wdState_t;

  logic [11:0] psQ;
  logic        refNd;
  logic [2:0]  pendQ;
  logic [2:0]  pendNext;
  logic        refOvfQ;
  logic        refRqQ;
  logic        tick;
  logic        ack;
  logic        ovfSet;

  wdState_t    state;
  wdState_t    stateNext;
  logic [11:0] tcQ;
  logic [11:0] tcNext;
  logic        armQ;
  logic        armNext;
  logic        toutQ;

  assign tick = ENREF && (psQ == PS_LAST);
  assign ack  = refNd && !REF_n;

  // Tick and ack on the same edge cancel each other out.
  always_comb begin
    pendNext = pendQ;
    ovfSet   = 1'b0;
    if (!ENREF) begin
      pendNext = 3'd0;
    end else if (tick && !ack) begin
      if (pendQ < PEND_TOP) begin
        pendNext = pendQ + 3'd1;
      end else begin
        ovfSet = 1'b1;
      end
    end else if (ack && !tick) begin
      if (pendQ != 3'd0) begin
        pendNext = pendQ - 3'd1;
      end
    end
  end

  always_ff @(posedge OSC or negedge CLEAR_n) begin
    if (!CLEAR_n) begin
      psQ     <= 12'd0;
      refNd   <= 1'b1;
      pendQ   <= 3'd0;
      refOvfQ <= 1'b0;
      refRqQ  <= 1'b1;
    end else begin
      if (!ENREF || tick) begin
        psQ <= 12'd0;
      end else begin
        psQ <= psQ + 12'd1;
      end
      refNd   <= REF_n;
      pendQ   <= pendNext;
      refRqQ  <= (pendNext == 3'd0);
      if (ovfSet) begin
        refOvfQ <= 1'b1;
      end
    end
  end

  // The arm bit blocks a new cycle until BDAP_n has been seen high in IDLE.
  always_comb begin
    stateNext = state;
    tcNext    = tcQ;
    armNext   = armQ;
    case (state)
      S_IDLE: begin
        if (BDAP_n) begin
          armNext = 1'b1;
        end else if (armQ) begin
          stateNext = S_WAIT;
          tcNext    = 12'd0;
          armNext   = 1'b0;
        end
      end
      S_WAIT: begin
        if (!BDRY_n) begin
          stateNext = S_IDLE;
        end else if (BDAP_n) begin
          stateNext = S_IDLE;
        end else if (tcQ == TC_LAST) begin
          stateNext = S_EXPIRED;
        end else begin
          tcNext = tcQ + 12'd1;
        end
      end
      S_EXPIRED: begin
        if (BDAP_n) begin
          stateNext = S_IDLE;
        end
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge OSC or negedge CLEAR_n) begin
    if (!CLEAR_n) begin
      state <= S_IDLE;
      tcQ   <= 12'd0;
      armQ  <= 1'b1;
      toutQ <= 1'b0;
    end else begin
      state <= stateNext;
      tcQ   <= tcNext;
      armQ  <= armNext;
      toutQ <= (stateNext == S_EXPIRED);
    end
  end

  assign REFRQ_n  = refRqQ;
  assign TOUT     = toutQ;
  assign REFOVF   = refOvfQ;
  assign PEND_CNT = pendQ;

endmodule
